// File: rtl/startup_pkg.sv
// Shared constants for the power-up sequencer: state encoding and widths.
package startup_pkg;

    localparam int STATE_W = 4;
    localparam int TIMER_W = 16;

    localparam logic [STATE_W-1:0] ST_RESET      = 4'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK  = 4'd1;
    localparam logic [STATE_W-1:0] ST_MEM_RST    = 4'd2;
    localparam logic [STATE_W-1:0] ST_MEM_CAL    = 4'd3;
    localparam logic [STATE_W-1:0] ST_CAM_PWDN   = 4'd4;
    localparam logic [STATE_W-1:0] ST_CAM_RST    = 4'd5;
    localparam logic [STATE_W-1:0] ST_CAM_SETTLE = 4'd6;
    localparam logic [STATE_W-1:0] ST_CAM_CFG    = 4'd7;
    localparam logic [STATE_W-1:0] ST_READY      = 4'd8;
    localparam logic [STATE_W-1:0] ST_FAULT      = 4'd9;

endpackage

// File: rtl/tick_timer.sv
// Shared tick counter: counts enabled tick pulses, saturates instead of wrapping,
// and flags the tick that completes the programmed limit.
module tick_timer
    import startup_pkg::*;
(
    input  logic               pll_outclk_0,
    input  logic               rst,
    input  logic               clear,
    input  logic               tick_en,
    input  logic [TIMER_W-1:0] limit,
    output logic               done
);

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear wins, otherwise advance on a tick unless already saturated
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick_en && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Done is the tick that lands while the count already sits at limit-1
    always_comb begin
        done = tick_en && (count_q == (limit - ONE));
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge pll_outclk_0) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sys_startup_seq.sv
// Power-up sequencer: memory reset and calibration, then camera power/reset/settle
// and configuration, with bounded retries, a sticky fault and lock-loss recovery.
module sys_startup_seq
    import startup_pkg::*;
#(
    parameter logic [TIMER_W-1:0] MEM_RST_US = 16'd200,
    parameter logic [TIMER_W-1:0] CAL_TO_MS  = 16'd500,
    parameter logic [TIMER_W-1:0] PWDN_MS    = 16'd10,
    parameter logic [TIMER_W-1:0] CRST_MS    = 16'd5,
    parameter logic [TIMER_W-1:0] SETTLE_MS  = 16'd20,
    parameter logic [TIMER_W-1:0] CFG_TO_MS  = 16'd1000,
    parameter logic [1:0]         MAX_RETRY  = 2'd2
) (
    input  logic               pll_outclk_0,
    input  logic               rst,
    input  logic               us_tck,
    input  logic               ms_tck,
    input  logic               pll_locked,
    input  logic               mem_cal_done,
    input  logic [1:0]         cam_cfg_done,
    output logic               mem_rst_n,
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               cam_cfg_start,
    output logic               sys_ready,
    output logic               fault,
    output logic [STATE_W-1:0] seq_state
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         retry_q, retry_d;
    logic               mem_rst_n_q, mem_rst_n_d;
    logic               cam_pwdn_q, cam_pwdn_d;
    logic               cam_rst_n_q, cam_rst_n_d;
    logic               cam_cfg_start_q, cam_cfg_start_d;
    logic               sys_ready_q, sys_ready_d;
    logic               fault_q, fault_d;

    logic               tick_en;
    logic [TIMER_W-1:0] limit;
    logic               timer_clear;
    logic               timer_done;
    logic               lock_lost;

    // Pick the tick source and duration belonging to the current state
    always_comb begin
        tick_en = 1'b0;
        limit   = TIMER_W'(1);
        case (state_q)
            ST_MEM_RST:    begin tick_en = us_tck; limit = MEM_RST_US; end
            ST_MEM_CAL:    begin tick_en = ms_tck; limit = CAL_TO_MS;  end
            ST_CAM_PWDN:   begin tick_en = ms_tck; limit = PWDN_MS;    end
            ST_CAM_RST:    begin tick_en = ms_tck; limit = CRST_MS;    end
            ST_CAM_SETTLE: begin tick_en = ms_tck; limit = SETTLE_MS;  end
            ST_CAM_CFG:    begin tick_en = ms_tck; limit = CFG_TO_MS;  end
            default:       begin tick_en = 1'b0;   limit = TIMER_W'(1); end
        endcase
    end

    // Restart the timer on every state change so each state counts from zero
    always_comb begin
        timer_clear = (state_d != state_q);
    end

    tick_timer u_tick_timer (
        .pll_outclk_0 (pll_outclk_0),
        .rst          (rst),
        .clear        (timer_clear),
        .tick_en      (tick_en),
        .limit        (limit),
        .done         (timer_done)
    );

    // Sequencing decisions: lock loss first, then done signals ahead of timeouts
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        lock_lost = !pll_locked && (state_q != ST_RESET) &&
                    (state_q != ST_WAIT_LOCK) && (state_q != ST_FAULT);
        if (lock_lost) begin
            state_d = ST_WAIT_LOCK;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET:     state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: if (pll_locked) state_d = ST_MEM_RST;
                ST_MEM_RST:   if (timer_done) state_d = ST_MEM_CAL;
                ST_MEM_CAL: begin
                    if (mem_cal_done) begin
                        state_d = ST_CAM_PWDN;
                    end else if (timer_done) begin
                        if (retry_q == MAX_RETRY) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_MEM_RST;
                            retry_d = retry_q + 2'd1;
                        end
                    end
                end
                ST_CAM_PWDN:   if (timer_done) state_d = ST_CAM_RST;
                ST_CAM_RST:    if (timer_done) state_d = ST_CAM_SETTLE;
                ST_CAM_SETTLE: if (timer_done) state_d = ST_CAM_CFG;
                ST_CAM_CFG: begin
                    if (cam_cfg_done == 2'b11) begin
                        state_d = ST_READY;
                    end else if (timer_done) begin
                        if (retry_q == MAX_RETRY) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_CAM_PWDN;
                            retry_d = retry_q + 2'd1;
                        end
                    end
                end
                ST_READY: state_d = ST_READY;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RESET;
            endcase
            if (state_d == ST_READY) begin
                retry_d = '0;
            end
        end
    end

    // Output levels follow the next state so they move with the state register
    always_comb begin
        mem_rst_n_d = 1'b0;
        cam_pwdn_d  = 1'b1;
        cam_rst_n_d = 1'b0;
        case (state_d)
            ST_MEM_CAL, ST_CAM_PWDN: begin
                mem_rst_n_d = 1'b1;
            end
            ST_CAM_RST: begin
                mem_rst_n_d = 1'b1;
                cam_pwdn_d  = 1'b0;
            end
            ST_CAM_SETTLE, ST_CAM_CFG, ST_READY: begin
                mem_rst_n_d = 1'b1;
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
            end
            default: begin
                mem_rst_n_d = 1'b0;
                cam_pwdn_d  = 1'b1;
                cam_rst_n_d = 1'b0;
            end
        endcase
        cam_cfg_start_d = (state_d == ST_CAM_CFG) && (state_q != ST_CAM_CFG);
        sys_ready_d     = (state_d == ST_READY);
        fault_d         = fault_q || (state_d == ST_FAULT);
    end

    // State, retry count and registered outputs with synchronous active-low reset
    always_ff @(posedge pll_outclk_0) begin
        if (!rst) begin
            state_q         <= ST_RESET;
            retry_q         <= '0;
            mem_rst_n_q     <= 1'b0;
            cam_pwdn_q      <= 1'b1;
            cam_rst_n_q     <= 1'b0;
            cam_cfg_start_q <= 1'b0;
            sys_ready_q     <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            retry_q         <= retry_d;
            mem_rst_n_q     <= mem_rst_n_d;
            cam_pwdn_q      <= cam_pwdn_d;
            cam_rst_n_q     <= cam_rst_n_d;
            cam_cfg_start_q <= cam_cfg_start_d;
            sys_ready_q     <= sys_ready_d;
            fault_q         <= fault_d;
        end
    end

    assign mem_rst_n     = mem_rst_n_q;
    assign cam_pwdn      = cam_pwdn_q;
    assign cam_rst_n     = cam_rst_n_q;
    assign cam_cfg_start = cam_cfg_start_q;
    assign sys_ready     = sys_ready_q;
    assign fault         = fault_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_sys_startup_seq.sv
// Self-checking bench for sys_startup_seq: random tick strobes, a behavioural
// model that counts ticks per phase, and one task per scenario.
module tb_sys_startup_seq;

    logic       pll_outclk_0 = 1'b0;
    logic       rst = 1'b0;
    logic       us_tck = 1'b0;
    logic       ms_tck = 1'b0;
    logic       pll_locked = 1'b0;
    logic       mem_cal_done = 1'b0;
    logic [1:0] cam_cfg_done = 2'b00;
    logic       mem_rst_n, cam_pwdn, cam_rst_n, cam_cfg_start, sys_ready, fault;
    logic [3:0] seq_state;
    logic [9:0] dut_vec;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model state: phase number, ticks seen in this phase, retries used
    int m_state = 0;
    int m_ticks = 0;
    int m_retry = 0;
    bit m_fault = 0;
    bit m_start = 0;
    int m_cal_entries = 0;
    bit mask_cfg_ms = 0;

    sys_startup_seq #(
        .MEM_RST_US (16'd4),
        .CAL_TO_MS  (16'd3),
        .PWDN_MS    (16'd2),
        .CRST_MS    (16'd2),
        .SETTLE_MS  (16'd2),
        .CFG_TO_MS  (16'd3),
        .MAX_RETRY  (2'd1)
    ) dut (
        .pll_outclk_0  (pll_outclk_0),
        .rst           (rst),
        .us_tck        (us_tck),
        .ms_tck        (ms_tck),
        .pll_locked    (pll_locked),
        .mem_cal_done  (mem_cal_done),
        .cam_cfg_done  (cam_cfg_done),
        .mem_rst_n     (mem_rst_n),
        .cam_pwdn      (cam_pwdn),
        .cam_rst_n     (cam_rst_n),
        .cam_cfg_start (cam_cfg_start),
        .sys_ready     (sys_ready),
        .fault         (fault),
        .seq_state     (seq_state)
    );

    assign dut_vec = {seq_state, mem_rst_n, cam_pwdn, cam_rst_n, cam_cfg_start, sys_ready, fault};

    always #5 pll_outclk_0 = ~pll_outclk_0;

    // Length of each timed phase in ticks; 0 means untimed
    function automatic int phase_len(int s);
        case (s)
            2: return 4;
            3: return 3;
            4: return 2;
            5: return 2;
            6: return 2;
            7: return 3;
            default: return 0;
        endcase
    endfunction

    // Expected output word for the model's current phase
    function automatic logic [9:0] model_vec();
        logic m, p, c, r;
        m = (m_state >= 3 && m_state <= 8);
        p = (m_state <= 4 || m_state == 9);
        c = (m_state >= 6 && m_state <= 8);
        r = (m_state == 8);
        return {4'(m_state), m, p, c, m_start, r, m_fault};
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        int nxt;
        bit tk;
        bit expired;
        if (!rst) begin
            m_state = 0; m_ticks = 0; m_retry = 0; m_fault = 0; m_start = 0;
            return;
        end
        tk = (m_state == 2) ? us_tck : ((m_state >= 3 && m_state <= 7) ? ms_tck : 1'b0);
        expired = tk && (m_ticks + 1 == phase_len(m_state));
        nxt = m_state;
        if (m_state >= 2 && m_state <= 8 && !pll_locked) begin
            nxt = 1;
            m_retry = 0;
        end else begin
            case (m_state)
                0: nxt = 1;
                1: if (pll_locked) nxt = 2;
                2: if (expired) nxt = 3;
                3: if (mem_cal_done) nxt = 4;
                   else if (expired) begin
                       if (m_retry >= 1) nxt = 9; else begin nxt = 2; m_retry++; end
                   end
                4: if (expired) nxt = 5;
                5: if (expired) nxt = 6;
                6: if (expired) nxt = 7;
                7: if (cam_cfg_done == 2'b11) nxt = 8;
                   else if (expired) begin
                       if (m_retry >= 1) nxt = 9; else begin nxt = 4; m_retry++; end
                   end
                default: nxt = m_state;
            endcase
        end
        m_start = (nxt == 7) && (m_state != 7);
        if (nxt == 8) m_retry = 0;
        if (nxt == 9) m_fault = 1;
        if (nxt != m_state) begin
            m_ticks = 0;
            if (nxt == 3) m_cal_entries++;
        end else begin
            m_ticks += int'(tk);
        end
        m_state = nxt;
    endtask

    task automatic gen_ticks();
        us_tck = ($urandom_range(0, 1) == 0);
        ms_tck = ($urandom_range(0, 2) == 0);
        if (mask_cfg_ms && m_state == 7) ms_tck = 1'b0;
    endtask

    task automatic step();
        model_update();
        @(posedge pll_outclk_0);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b0; cam_cfg_done = 2'b00;
        gen_ticks(); step();
        gen_ticks(); step();
        n_cmp++;
        if (dut_vec !== 10'b0000_0_1_0_0_0_0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b want %b", dut_vec, 10'b0000_0_1_0_0_0_0);
        end
        rst = 1'b1;
        gen_ticks(); step();
        n_cmp++;
        if (seq_state !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL reset_to_wait_lock: got %0d want 1", seq_state);
        end
    endtask

    task automatic test_nominal();
        int seen[$];
        int exp_order[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        int tick_cnt[10];
        int starts = 0;
        int cfg_wait = -1;
        logic [3:0] prev;
        foreach (tick_cnt[k]) tick_cnt[k] = 0;
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b0; cam_cfg_done = 2'b00;
        mask_cfg_ms = 1;
        gen_ticks(); step();
        rst = 1'b1;
        prev = seq_state;
        for (int i = 0; i < 2000 && m_state != 8; i++) begin
            if (m_state == 3 && m_ticks >= 2) mem_cal_done = 1'b1;
            if (m_start) cfg_wait = 0; else if (cfg_wait >= 0) cfg_wait++;
            if (cfg_wait >= 5) cam_cfg_done = 2'b11;
            gen_ticks();
            if (seq_state == 4'd2 && us_tck) tick_cnt[2]++;
            if (seq_state >= 4'd4 && seq_state <= 4'd6 && ms_tck) tick_cnt[seq_state]++;
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL nominal_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
            if (cam_cfg_start) starts++;
            if (seq_state != prev) seen.push_back(int'(seq_state));
            prev = seq_state;
        end
        mask_cfg_ms = 0;
        n_cmp++;
        if (seen.size() != 8) begin
            n_fail++;
            $display("[TB] FAIL nominal_order_len: got %0d want 8", seen.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (seen[k] != exp_order[k]) begin
                    n_fail++;
                    $display("[TB] FAIL nominal_order[%0d]: got %0d want %0d", k, seen[k], exp_order[k]);
                end
            end
        end
        n_cmp++;
        if (tick_cnt[2] != 4) begin
            n_fail++; $display("[TB] FAIL mem_rst_ticks: got %0d want 4", tick_cnt[2]);
        end
        for (int s = 4; s <= 6; s++) begin
            n_cmp++;
            if (tick_cnt[s] != 2) begin
                n_fail++; $display("[TB] FAIL cam_ticks[%0d]: got %0d want 2", s, tick_cnt[s]);
            end
        end
        n_cmp++;
        if (starts != 1) begin
            n_fail++; $display("[TB] FAIL nominal_start_pulses: got %0d want 1", starts);
        end
        for (int i = 0; i < 5; i++) begin gen_ticks(); step(); end
        n_cmp++;
        if (sys_ready !== 1'b1 || seq_state !== 4'd8) begin
            n_fail++; $display("[TB] FAIL nominal_ready: got ready=%b state=%0d want 1/8", sys_ready, seq_state);
        end
    endtask

    task automatic test_cal_timeout();
        int rst_entries = 0;
        int cal_ticks = 0;
        logic [3:0] prev;
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b0; cam_cfg_done = 2'b00;
        gen_ticks(); step();
        rst = 1'b1;
        prev = seq_state;
        for (int i = 0; i < 2000 && m_state != 9; i++) begin
            gen_ticks();
            if (seq_state == 4'd3 && ms_tck) cal_ticks++;
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL cal_timeout_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
            if (seq_state == 4'd2 && prev != 4'd2) rst_entries++;
            prev = seq_state;
        end
        n_cmp++;
        if (rst_entries != 2) begin
            n_fail++; $display("[TB] FAIL cal_mem_rst_entries: got %0d want 2", rst_entries);
        end
        n_cmp++;
        if (cal_ticks != 6) begin
            n_fail++; $display("[TB] FAIL cal_timeout_ticks: got %0d want 6", cal_ticks);
        end
        n_cmp++;
        if (fault !== 1'b1 || mem_rst_n !== 1'b0 || seq_state !== 4'd9) begin
            n_fail++;
            $display("[TB] FAIL cal_fault: got fault=%b mem_rst_n=%b state=%0d want 1/0/9", fault, mem_rst_n, seq_state);
        end
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin gen_ticks(); step(); end
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) begin gen_ticks(); step(); end
        n_cmp++;
        if (fault !== 1'b1 || seq_state !== 4'd9 || sys_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fault_sticky: got fault=%b state=%0d ready=%b want 1/9/0", fault, seq_state, sys_ready);
        end
    endtask

    task automatic test_cfg_partial();
        int starts = 0;
        int pwdn_entries = 0;
        logic [3:0] prev;
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b1; cam_cfg_done = 2'b01;
        gen_ticks(); step();
        rst = 1'b1;
        prev = seq_state;
        for (int i = 0; i < 2000 && m_state != 9; i++) begin
            gen_ticks();
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL cfg_partial_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
            if (cam_cfg_start) starts++;
            if (seq_state == 4'd4 && prev != 4'd4) pwdn_entries++;
            prev = seq_state;
        end
        n_cmp++;
        if (starts != 2) begin
            n_fail++; $display("[TB] FAIL cfg_start_pulses: got %0d want 2", starts);
        end
        n_cmp++;
        if (pwdn_entries != 2) begin
            n_fail++; $display("[TB] FAIL cfg_pwdn_entries: got %0d want 2", pwdn_entries);
        end
        n_cmp++;
        if (fault !== 1'b1 || seq_state !== 4'd9) begin
            n_fail++; $display("[TB] FAIL cfg_fault: got fault=%b state=%0d want 1/9", fault, seq_state);
        end
    endtask

    task automatic test_lock_loss();
        int rst_entries = 0;
        logic [3:0] prev;
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b0; cam_cfg_done = 2'b00;
        gen_ticks(); step();
        rst = 1'b1;
        m_cal_entries = 0;
        for (int i = 0; i < 2000 && m_state != 6; i++) begin
            mem_cal_done = (m_cal_entries >= 2);
            gen_ticks();
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL lock_phase1_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
        end
        n_cmp++;
        if (seq_state !== 4'd6) begin
            n_fail++; $display("[TB] FAIL lock_reach_settle: got %0d want 6", seq_state);
        end
        pll_locked = 1'b0;
        gen_ticks(); step();
        n_cmp++;
        if (seq_state !== 4'd1 || mem_rst_n !== 1'b0 || cam_pwdn !== 1'b1 || cam_rst_n !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lock_loss_outputs: got state=%0d mem=%b pwdn=%b crst=%b want 1/0/1/0",
                     seq_state, mem_rst_n, cam_pwdn, cam_rst_n);
        end
        pll_locked = 1'b1;
        m_cal_entries = 0;
        prev = seq_state;
        for (int i = 0; i < 2000 && m_state != 8; i++) begin
            mem_cal_done = (m_cal_entries >= 2);
            cam_cfg_done = (m_state == 7) ? 2'b11 : 2'b00;
            gen_ticks();
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL lock_phase2_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
            if (seq_state == 4'd2 && prev != 4'd2) rst_entries++;
            prev = seq_state;
        end
        n_cmp++;
        if (rst_entries != 2) begin
            n_fail++; $display("[TB] FAIL relock_mem_rst_entries: got %0d want 2", rst_entries);
        end
        n_cmp++;
        if (sys_ready !== 1'b1 || fault !== 1'b0) begin
            n_fail++; $display("[TB] FAIL relock_ready: got ready=%b fault=%b want 1/0", sys_ready, fault);
        end
    endtask

    task automatic test_tie();
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b1; cam_cfg_done = 2'b00;
        gen_ticks(); step();
        rst = 1'b1;
        for (int i = 0; i < 2000 && m_state != 7; i++) begin
            gen_ticks();
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL tie_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
        end
        for (int k = 0; k < 4; k++) begin
            us_tck = 1'b0;
            ms_tck = (k != 1);
            cam_cfg_done = (k == 3) ? 2'b11 : 2'b00;
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL tie_cfg_trace: got %b want %b step %0d", dut_vec, model_vec(), k);
            end
        end
        n_cmp++;
        if (seq_state !== 4'd8 || sys_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL tie_done_wins: got state=%0d ready=%b want 8/1", seq_state, sys_ready);
        end
    endtask

    task automatic test_midrun_reset();
        rst = 1'b0; pll_locked = 1'b1; mem_cal_done = 1'b1; cam_cfg_done = 2'b00;
        gen_ticks(); step();
        rst = 1'b1;
        for (int i = 0; i < 2000 && m_state != 5; i++) begin
            gen_ticks();
            step();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL midrun_trace: got %b want %b cycle %0d", dut_vec, model_vec(), i);
            end
        end
        rst = 1'b0;
        gen_ticks(); step();
        n_cmp++;
        if (dut_vec !== 10'b0000_0_1_0_0_0_0) begin
            n_fail++; $display("[TB] FAIL midrun_reset_outputs: got %b want %b", dut_vec, 10'b0000_0_1_0_0_0_0);
        end
        rst = 1'b1;
        gen_ticks(); step();
        n_cmp++;
        if (seq_state !== 4'd1) begin
            n_fail++; $display("[TB] FAIL midrun_release: got %0d want 1", seq_state);
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        test_reset();
        test_nominal();
        test_cal_timeout();
        test_cfg_partial();
        test_lock_loss();
        test_tie();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
